// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned NumReqDefault = 4;
  localparam int unsigned GapMaxDefault = 255;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StSend,
    StWait
  } arb_state_e;

  // Next requester index after idx, wrapping at n.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for the UART transmit arbiter.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned num_req = NumReqDefault
);
  logic [8*num_req-1:0] i_req_data;
  logic [num_req-1:0]   i_req_valid;
  logic [num_req-1:0]   i_req_last;
  logic [num_req-1:0]   o_req_ready;
  logic [7:0]           o_tx_data;
  logic                 o_tx_req;
  logic                 i_tx_cts;

  // Requesters and transmitter side.
  modport master (
    output i_req_data, i_req_valid, i_req_last, i_tx_cts,
    input  o_req_ready, o_tx_data, o_tx_req
  );

  // Arbiter side.
  modport slave (
    input  i_req_data, i_req_valid, i_req_last, i_tx_cts,
    output o_req_ready, o_tx_data, o_tx_req
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_ptr, with wrap.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned num_req = NumReqDefault
) (
  input  logic [num_req-1:0]         valid,
  input  logic [$clog2(num_req)-1:0] rr_ptr,
  output logic [$clog2(num_req)-1:0] winner,
  output logic                       any
);
  localparam int unsigned IdxW = $clog2(num_req);

  // Scan upward from rr_ptr; the first hit wins.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < num_req; i++) begin
      automatic logic [IdxW-1:0] idx = IdxW'((32'(rr_ptr) + i) % num_req);
      if (!any && valid[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locking round-robin arbiter feeding bytes from several requesters to one UART
// transmitter. A granted requester keeps the lock until its last byte is accepted or it
// stalls for gap_max cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned num_req = NumReqDefault,
  parameter int unsigned gap_max = GapMaxDefault
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(num_req)-1:0] o_owner,
  output logic                       o_busy,
  output logic                       o_abort
);
  localparam int unsigned OwnerW = $clog2(num_req);
  localparam int unsigned GapW   = $clog2(gap_max + 1);
  localparam logic [GapW-1:0] GapMax  = GapW'(gap_max);
  // Abort fires on the idle cycle whose increment would reach gap_max.
  localparam logic [GapW-1:0] GapLast = GapW'(gap_max - 1);

  arb_state_e          state_q;
  logic [OwnerW-1:0]   owner_q;
  logic [OwnerW-1:0]   rr_ptr_q;
  logic [GapW-1:0]     gap_q;
  logic                last_q;
  logic [7:0]          tx_data_q;
  logic                tx_req_q;
  logic                abort_q;

  logic [OwnerW-1:0]   pick_idx;
  logic                pick_any;
  logic [OwnerW-1:0]   owner_next;
  logic [7:0]          owner_data;
  logic                owner_valid;
  logic                owner_last;
  logic [num_req-1:0]  ready;

  rr_pick #(
    .num_req(num_req)
  ) u_rr_pick (
    .valid (bus.i_req_valid),
    .rr_ptr(rr_ptr_q),
    .winner(pick_idx),
    .any   (pick_any)
  );

  // Select the lock holder's lane and decode its one-hot ready strobe.
  always_comb begin
    owner_data  = 8'h00;
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    for (int unsigned k = 0; k < num_req; k++) begin
      if (owner_q == OwnerW'(k)) begin
        owner_data  = bus.i_req_data[8*k +: 8];
        owner_valid = bus.i_req_valid[k];
        owner_last  = bus.i_req_last[k];
      end
    end
    owner_next = OwnerW'(wrap_inc(32'(owner_q), num_req));
    ready      = '0;
    if (state_q == StLoad) begin
      ready[owner_q] = 1'b1;
    end
  end

  // Arbitration FSM with registered transmitter-facing outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      gap_q     <= '0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
      tx_req_q  <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_any) begin
            owner_q <= pick_idx;
            gap_q   <= '0;
            state_q <= StLoad;
          end
        end
        StLoad: begin
          if (owner_valid) begin
            tx_data_q <= owner_data;
            last_q    <= owner_last;
            gap_q     <= '0;
            tx_req_q  <= 1'b1;
            state_q   <= StSend;
          end else begin
            if (gap_q != GapMax) begin
              gap_q <= gap_q + 1'b1;
            end
            if (gap_q >= GapLast) begin
              abort_q  <= 1'b1;
              rr_ptr_q <= owner_next;
              state_q  <= StIdle;
            end
          end
        end
        StSend: begin
          // A falling cts is the only sign the transmitter took the byte.
          if (!bus.i_tx_cts) begin
            tx_req_q <= 1'b0;
            state_q  <= StWait;
          end
        end
        StWait: begin
          if (bus.i_tx_cts) begin
            if (last_q) begin
              rr_ptr_q <= owner_next;
              state_q  <= StIdle;
            end else begin
              state_q <= StLoad;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_req_ready = ready;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_req    = tx_req_q;
  assign o_owner         = owner_q;
  assign o_busy          = (state_q != StIdle);
  assign o_abort         = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized packet
// traffic scored against a round-robin packet-order model.
module tb_uart_tx_arbiter;
  localparam int N    = 4;
  localparam int GMAX = 4;
  localparam int DW   = 8 * N;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] owner;
  logic       busy;
  logic       abort;

  int n_cmp = 0;
  int n_err = 0;

  // Per-requester byte queues: bit 8 marks the last byte of a packet.
  logic [8:0] mem [N][64];
  int         head [N];
  int         tail [N];

  logic [7:0] exp_b [$];
  int         exp_o [$];

  uart_tx_arbiter_if #(.num_req(N)) bus ();

  uart_tx_arbiter #(
    .num_req(N),
    .gap_max(GMAX)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .o_owner(owner),
    .o_busy (busy),
    .o_abort(abort)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
    bus.i_req_valid = (bus.i_req_valid & ~(N'(1) << k)) | (N'(v) << k);
    bus.i_req_last  = (bus.i_req_last & ~(N'(1) << k)) | (N'(l) << k);
    bus.i_req_data  = (bus.i_req_data & ~(DW'(8'hFF) << (8 * k))) | (DW'(d) << (8 * k));
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;
    bus.i_tx_cts    = 1'b1;
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_byte(input int k, input logic [7:0] b, input logic l);
    mem[k][tail[k]] = {l, b};
    tail[k]++;
  endtask

  // Present each queue head; idle lanes carry junk the arbiter must ignore.
  task automatic drive_reqs();
    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic [DW-1:0] d;
    logic [8:0]    e;
    v = '0;
    l = N'($urandom);
    d = DW'($urandom);
    for (int k = 0; k < N; k++) begin
      if (head[k] < tail[k]) begin
        e = mem[k][head[k]];
        v = v | (N'(1) << k);
        l = (l & ~(N'(1) << k)) | (N'(e[8]) << k);
        d = (d & ~(DW'(8'hFF) << (8 * k))) | (DW'(e[7:0]) << (8 * k));
      end
    end
    bus.i_req_valid = v;
    bus.i_req_last  = l;
    bus.i_req_data  = d;
  endtask

  // Reference order: whole packets, round robin over non-empty queues from pointer 0.
  task automatic build_model();
    int         h [N];
    int         ptr;
    int         win;
    bit         go;
    logic [8:0] e;
    ptr = 0;
    go  = 1'b1;
    for (int k = 0; k < N; k++) h[k] = head[k];
    while (go) begin
      win = -1;
      for (int i = 0; i < N; i++) begin
        int c;
        c = (ptr + i) % N;
        if (win < 0 && h[c] < tail[c]) win = c;
      end
      if (win < 0) begin
        go = 1'b0;
      end else begin
        do begin
          e = mem[win][h[win]];
          h[win]++;
          exp_b.push_back(e[7:0]);
          exp_o.push_back(win);
        end while (!e[8]);
        ptr = (win + 1) % N;
      end
    end
  endtask

  // Requester and transmitter BFMs; checks every strobe and byte against exp_b/exp_o.
  task automatic run_engine(input int budget);
    int           tx_idx;
    int           pop_idx;
    int           hold;
    int           wait_cnt;
    int           cyc;
    bit           tx_busy;
    bit           done;
    logic [N-1:0] hs;
    tx_idx       = 0;
    pop_idx      = 0;
    cyc          = 0;
    tx_busy      = 1'b0;
    done         = 1'b0;
    wait_cnt     = 0;
    hold         = $urandom_range(0, 3);
    bus.i_tx_cts = 1'b1;
    drive_reqs();
    while (!done && cyc < budget) begin
      @(negedge clk);
      hs = bus.o_req_ready & bus.i_req_valid;
      if (bus.o_req_ready != '0) begin
        if (pop_idx < exp_b.size()) begin
          check_eq("ready_owner", 32'(bus.o_req_ready), 32'(1) << exp_o[pop_idx]);
        end else begin
          check_eq("ready_extra", 32'(bus.o_req_ready), 32'(0));
        end
      end
      if (!tx_busy) begin
        if (bus.o_tx_req) begin
          if (tx_idx < exp_b.size()) begin
            check_eq("tx_data", 32'(bus.o_tx_data), 32'(exp_b[tx_idx]));
            check_eq("tx_owner", 32'(owner), 32'(exp_o[tx_idx]));
          end else begin
            check_eq("tx_extra", 32'(bus.o_tx_req), 32'(0));
          end
          if (hold == 0) begin
            bus.i_tx_cts = 1'b0;
            tx_busy      = 1'b1;
            tx_idx++;
            wait_cnt     = $urandom_range(0, 3);
          end else begin
            hold--;
          end
        end
      end else if (wait_cnt == 0) begin
        bus.i_tx_cts = 1'b1;
        tx_busy      = 1'b0;
        hold         = $urandom_range(0, 3);
      end else begin
        wait_cnt--;
      end
      if (tx_idx == exp_b.size() && pop_idx == exp_b.size() && !tx_busy && !busy) done = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (hs[k]) begin
          head[k]++;
          pop_idx++;
        end
      end
      drive_reqs();
      cyc++;
    end
    check_eq("engine_done", 32'(done), 32'(1));
    check_eq("bytes_sent", 32'(tx_idx), 32'(exp_b.size()));
    exp_b.delete();
    exp_o.delete();
  endtask

  initial begin
    // Reset values, asserted asynchronously between clock edges.
    rst_n           = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_last  = '0;
    bus.i_req_data  = '0;
    bus.i_tx_cts    = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_tx_req", 32'(bus.o_tx_req), 32'(0));
    check_eq("rst_tx_data", 32'(bus.o_tx_data), 32'(0));
    check_eq("rst_abort", 32'(abort), 32'(0));
    check_eq("rst_owner", 32'(owner), 32'(0));
    check_eq("rst_ready", 32'(bus.o_req_ready), 32'(0));

    // Single-byte packet latency and pointer advance.
    do_reset();
    set_req(0, 1'b1, 8'hA5, 1'b1);
    check_eq("lat_t0_ready", 32'(bus.o_req_ready), 32'(0));
    tick();
    check_eq("lat_t1_ready", 32'(bus.o_req_ready), 32'(4'b0001));
    check_eq("lat_t1_tx_req", 32'(bus.o_tx_req), 32'(0));
    check_eq("lat_t1_busy", 32'(busy), 32'(1));
    tick();
    check_eq("lat_t2_tx_req", 32'(bus.o_tx_req), 32'(1));
    check_eq("lat_t2_data", 32'(bus.o_tx_data), 32'(8'hA5));
    check_eq("lat_t2_ready", 32'(bus.o_req_ready), 32'(0));
    set_req(0, 1'b0, 8'h00, 1'b0);
    tick();
    check_eq("send_hold_req", 32'(bus.o_tx_req), 32'(1));
    bus.i_tx_cts = 1'b0;
    tick();
    check_eq("wait_req_low", 32'(bus.o_tx_req), 32'(0));
    check_eq("wait_busy", 32'(busy), 32'(1));
    bus.i_tx_cts = 1'b1;
    tick();
    check_eq("done_idle", 32'(busy), 32'(0));
    set_req(0, 1'b1, 8'h10, 1'b1);
    set_req(1, 1'b1, 8'h20, 1'b1);
    tick();
    check_eq("rr1_owner", 32'(owner), 32'(1));
    check_eq("rr1_ready", 32'(bus.o_req_ready), 32'(4'b0010));

    // Two multi-byte packets: the lock holds until the first packet's last byte.
    do_reset();
    push_byte(0, 8'h01, 1'b0);
    push_byte(0, 8'h02, 1'b0);
    push_byte(0, 8'h03, 1'b1);
    push_byte(2, 8'h11, 1'b0);
    push_byte(2, 8'h12, 1'b0);
    push_byte(2, 8'h13, 1'b1);
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13};
    exp_o = '{0, 0, 0, 2, 2, 2};
    run_engine(500);

    // Everyone always valid with single-byte packets: grant order wraps.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) push_byte(k, 8'(8'hC0 + k), 1'b1);
    end
    exp_b = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    exp_o = '{0, 1, 2, 3, 0, 1, 2, 3};
    run_engine(500);

    // Gap timeout: owner 1 stalls mid-packet while non-owners wait.
    do_reset();
    set_req(1, 1'b1, 8'h55, 1'b0);
    tick();
    check_eq("gap_grant", 32'(bus.o_req_ready), 32'(4'b0010));
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    bus.i_tx_cts = 1'b0;
    tick();
    bus.i_tx_cts = 1'b1;
    tick();
    check_eq("gap_load_ready", 32'(bus.o_req_ready), 32'(4'b0010));
    check_eq("gap_load_abort", 32'(abort), 32'(0));
    set_req(0, 1'b1, 8'h66, 1'b1);
    set_req(2, 1'b1, 8'h77, 1'b1);
    for (int i = 0; i < GMAX - 1; i++) begin
      tick();
      check_eq("gap_no_abort", 32'(abort), 32'(0));
      check_eq("gap_still_busy", 32'(busy), 32'(1));
      check_eq("gap_ready_held", 32'(bus.o_req_ready), 32'(4'b0010));
    end
    tick();
    check_eq("abort_pulse", 32'(abort), 32'(1));
    check_eq("abort_idle", 32'(busy), 32'(0));
    check_eq("abort_ready", 32'(bus.o_req_ready), 32'(0));
    tick();
    check_eq("abort_one_cycle", 32'(abort), 32'(0));
    check_eq("abort_rr_owner", 32'(owner), 32'(2));
    check_eq("abort_rr_ready", 32'(bus.o_req_ready), 32'(4'b0100));

    // Transmitter holds cts high: request and data stay put, other inputs ignored.
    do_reset();
    set_req(3, 1'b1, 8'h3C, 1'b1);
    tick();
    tick();
    check_eq("hold_req", 32'(bus.o_tx_req), 32'(1));
    check_eq("hold_data", 32'(bus.o_tx_data), 32'(8'h3C));
    for (int i = 0; i < 5; i++) begin
      bus.i_req_valid = N'($urandom);
      bus.i_req_last  = N'($urandom);
      bus.i_req_data  = DW'($urandom);
      tick();
      check_eq("hold_req_stable", 32'(bus.o_tx_req), 32'(1));
      check_eq("hold_data_stable", 32'(bus.o_tx_data), 32'(8'h3C));
      check_eq("hold_owner", 32'(owner), 32'(3));
    end
    bus.i_req_valid = '0;
    bus.i_tx_cts    = 1'b0;
    tick();
    check_eq("hold_wait_req", 32'(bus.o_tx_req), 32'(0));
    check_eq("hold_wait_busy", 32'(busy), 32'(1));
    bus.i_tx_cts = 1'b1;
    tick();
    check_eq("hold_idle", 32'(busy), 32'(0));

    // Reset in SEND after advancing the pointer: everything clears, pointer back to 0.
    do_reset();
    set_req(1, 1'b1, 8'h11, 1'b1);
    tick();
    tick();
    set_req(1, 1'b0, 8'h00, 1'b0);
    bus.i_tx_cts = 1'b0;
    tick();
    bus.i_tx_cts = 1'b1;
    tick();
    set_req(2, 1'b1, 8'h77, 1'b1);
    tick();
    tick();
    set_req(2, 1'b0, 8'h00, 1'b0);
    check_eq("mid_send_req", 32'(bus.o_tx_req), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_tx_req", 32'(bus.o_tx_req), 32'(0));
    check_eq("async_ready", 32'(bus.o_req_ready), 32'(0));
    check_eq("async_busy", 32'(busy), 32'(0));
    check_eq("async_data", 32'(bus.o_tx_data), 32'(0));
    check_eq("async_owner", 32'(owner), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("no_resend", 32'(bus.o_tx_req), 32'(0));
    end
    set_req(1, 1'b1, 8'h21, 1'b1);
    set_req(3, 1'b1, 8'h23, 1'b1);
    tick();
    check_eq("post_rst_owner", 32'(owner), 32'(1));

    // Randomized packet traffic against the round-robin packet model.
    for (int r = 0; r < 4; r++) begin
      logic [N-1:0] act;
      do_reset();
      act = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        if (act[k]) begin
          int npk;
          npk = $urandom_range(1, 3);
          for (int p = 0; p < npk; p++) begin
            int len;
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), b == len - 1);
          end
        end
      end
      build_model();
      run_engine(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
